// File: rtl/controle_multiciclo.sv
// Multi-cycle RISC-V control FSM: per-class stage skipping, parametrised wait states,
// memory-ready handshake with timeout, illegal-opcode trap and cycle/retire counters.
module controle_multiciclo #(
    parameter int EX_WAIT     = 2,
    parameter int WB_WAIT     = 2,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instrucao,
    input  logic        mem_ready,
    output logic [3:0]  estado,
    output logic        en_if,
    output logic        en_id,
    output logic        en_ex,
    output logic        en_mem,
    output logic        en_wb,
    output logic        en_pc,
    output logic        halted,
    output logic        erro,
    output logic [1:0]  causa,
    output logic [31:0] ciclos,
    output logic [31:0] instret
);

    localparam int MAX_EW = (EX_WAIT > WB_WAIT) ? EX_WAIT : WB_WAIT;
    localparam int MAX_W  = (MAX_EW > MEM_TIMEOUT) ? MAX_EW : MEM_TIMEOUT;
    localparam int CW     = $clog2(MAX_W + 1);

    // Last counter value of each wait window; unused when the matching wait is 0.
    localparam logic [CW-1:0] EX_LAST  = CW'(EX_WAIT - 1);
    localparam logic [CW-1:0] WB_LAST  = CW'(WB_WAIT - 1);
    localparam logic [CW-1:0] MEM_LAST = CW'(MEM_TIMEOUT - 1);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_ALU_R  = 7'b0110011;
    localparam logic [6:0] OP_ALU_I  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] CAUSA_NONE    = 2'b00;
    localparam logic [1:0] CAUSA_ILEGAL  = 2'b01;
    localparam logic [1:0] CAUSA_TIMEOUT = 2'b10;

    typedef enum logic [3:0] {
        S_IF    = 4'b0000,
        S_ID    = 4'b0001,
        S_EX    = 4'b0010,
        S_MEM   = 4'b0011,
        S_WB    = 4'b0100,
        S_EXW   = 4'b0101,
        S_WBW   = 4'b0110,
        S_SUMPC = 4'b1000,
        S_FIM   = 4'b1001,
        S_ERRO  = 4'b1010
    } state_t;

    typedef enum logic [1:0] {
        C_LOAD   = 2'd0,
        C_STORE  = 2'd1,
        C_ALU    = 2'd2,
        C_BRANCH = 2'd3
    } classe_t;

    state_t        state_r, state_nxt, pos_ex_s;
    classe_t       classe_r, classe_nxt;
    logic [1:0]    causa_r, causa_nxt;
    logic [CW-1:0] cnt_r, cnt_nxt;
    logic          waiting_s;

    assign estado = state_r;
    assign causa  = causa_r;

    // Destination after execute (and its optional wait window), chosen by latched class.
    always_comb begin
        pos_ex_s = S_SUMPC;
        case (classe_r)
            C_LOAD:   pos_ex_s = S_MEM;
            C_STORE:  pos_ex_s = S_MEM;
            C_ALU:    pos_ex_s = S_WB;
            C_BRANCH: pos_ex_s = S_SUMPC;
            default:  pos_ex_s = S_SUMPC;
        endcase
    end

    // Next-state, class latch, trap cause and shared wait counter.
    always_comb begin
        state_nxt  = state_r;
        classe_nxt = classe_r;
        causa_nxt  = causa_r;
        case (state_r)
            S_IF: state_nxt = S_ID;
            S_ID: begin
                if (instrucao == 32'd0) begin
                    state_nxt = S_FIM;
                end else begin
                    case (instrucao[6:0])
                        OP_LOAD: begin
                            classe_nxt = C_LOAD;
                            state_nxt  = S_EX;
                        end
                        OP_STORE: begin
                            classe_nxt = C_STORE;
                            state_nxt  = S_EX;
                        end
                        OP_ALU_R, OP_ALU_I: begin
                            classe_nxt = C_ALU;
                            state_nxt  = S_EX;
                        end
                        OP_BRANCH: begin
                            classe_nxt = C_BRANCH;
                            state_nxt  = S_EX;
                        end
                        default: begin
                            state_nxt = S_ERRO;
                            causa_nxt = CAUSA_ILEGAL;
                        end
                    endcase
                end
            end
            S_EX: begin
                if (EX_WAIT > 0) begin
                    state_nxt = S_EXW;
                end else begin
                    state_nxt = pos_ex_s;
                end
            end
            S_EXW: begin
                if (cnt_r == EX_LAST) begin
                    state_nxt = pos_ex_s;
                end else begin
                    state_nxt = S_EXW;
                end
            end
            S_MEM: begin
                // A ready arriving on the timeout cycle still counts as success.
                if (mem_ready) begin
                    state_nxt = (classe_r == C_LOAD) ? S_WB : S_SUMPC;
                end else if (cnt_r == MEM_LAST) begin
                    state_nxt = S_ERRO;
                    causa_nxt = CAUSA_TIMEOUT;
                end else begin
                    state_nxt = S_MEM;
                end
            end
            S_WB: begin
                if (WB_WAIT > 0) begin
                    state_nxt = S_WBW;
                end else begin
                    state_nxt = S_SUMPC;
                end
            end
            S_WBW: begin
                if (cnt_r == WB_LAST) begin
                    state_nxt = S_SUMPC;
                end else begin
                    state_nxt = S_WBW;
                end
            end
            S_SUMPC: state_nxt = S_IF;
            S_FIM:   state_nxt = S_FIM;
            S_ERRO:  state_nxt = S_ERRO;
            default: state_nxt = S_ERRO;
        endcase

        waiting_s = (state_r == S_EXW) || (state_r == S_WBW) || (state_r == S_MEM);
        if (state_nxt != state_r) begin
            cnt_nxt = '0;
        end else if (waiting_s) begin
            cnt_nxt = cnt_r + CW'(1);
        end else begin
            cnt_nxt = cnt_r;
        end
    end

    // State, counters and Moore output registers; reset overrides every transition.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= S_IF;
            classe_r <= C_ALU;
            causa_r  <= CAUSA_NONE;
            cnt_r    <= '0;
            ciclos   <= 32'd0;
            instret  <= 32'd0;
            en_if    <= 1'b1;
            en_id    <= 1'b0;
            en_ex    <= 1'b0;
            en_mem   <= 1'b0;
            en_wb    <= 1'b0;
            en_pc    <= 1'b0;
            halted   <= 1'b0;
            erro     <= 1'b0;
        end else begin
            state_r  <= state_nxt;
            classe_r <= classe_nxt;
            causa_r  <= causa_nxt;
            cnt_r    <= cnt_nxt;
            if (state_r != S_FIM && state_r != S_ERRO) begin
                ciclos <= ciclos + 32'd1;
            end else begin
                ciclos <= ciclos;
            end
            if (state_r == S_SUMPC) begin
                instret <= instret + 32'd1;
            end else begin
                instret <= instret;
            end
            en_if  <= (state_nxt == S_IF);
            en_id  <= (state_nxt == S_ID);
            en_ex  <= (state_nxt == S_EX);
            en_mem <= (state_nxt == S_MEM);
            en_wb  <= (state_nxt == S_WB);
            en_pc  <= (state_nxt == S_SUMPC);
            halted <= (state_nxt == S_FIM);
            erro   <= (state_nxt == S_ERRO);
        end
    end

endmodule

// File: tb/tb_controle_multiciclo.sv
// Bench for controle_multiciclo: table of whole-instruction vectors, hand-written
// reset/sticky sequences, and randomized instruction streams against a trace model.
module tb_controle_multiciclo;

    localparam logic [3:0] ST_IF = 4'h0, ST_ID = 4'h1, ST_EX = 4'h2, ST_MEM = 4'h3;
    localparam logic [3:0] ST_WB = 4'h4, ST_EXW = 4'h5, ST_WBW = 4'h6;
    localparam logic [3:0] ST_SUMPC = 4'h8, ST_FIM = 4'h9, ST_ERRO = 4'hA;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instrucao = 32'd0;
    logic        mem_ready = 1'b0;
    bit          sel = 1'b0;

    logic [3:0]  estado0, estado1;
    logic [5:0]  en0, en1;
    logic        halted0, halted1, erro0, erro1;
    logic [1:0]  causa0, causa1;
    logic [31:0] ciclos0, ciclos1, instret0, instret1;

    logic [3:0]  o_estado;
    logic [5:0]  o_en;
    logic        o_halted, o_erro;
    logic [1:0]  o_causa;
    logic [31:0] o_ciclos, o_instret;

    int checks = 0;
    int failures = 0;
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    controle_multiciclo dut0 (
        .clk(clk), .rst(rst), .instrucao(instrucao), .mem_ready(mem_ready),
        .estado(estado0), .en_if(en0[5]), .en_id(en0[4]), .en_ex(en0[3]),
        .en_mem(en0[2]), .en_wb(en0[1]), .en_pc(en0[0]), .halted(halted0),
        .erro(erro0), .causa(causa0), .ciclos(ciclos0), .instret(instret0)
    );

    controle_multiciclo #(.EX_WAIT(0), .WB_WAIT(0), .MEM_TIMEOUT(3)) dut1 (
        .clk(clk), .rst(rst), .instrucao(instrucao), .mem_ready(mem_ready),
        .estado(estado1), .en_if(en1[5]), .en_id(en1[4]), .en_ex(en1[3]),
        .en_mem(en1[2]), .en_wb(en1[1]), .en_pc(en1[0]), .halted(halted1),
        .erro(erro1), .causa(causa1), .ciclos(ciclos1), .instret(instret1)
    );

    always_comb begin
        if (sel) begin
            o_estado = estado1; o_en = en1; o_halted = halted1; o_erro = erro1;
            o_causa = causa1; o_ciclos = ciclos1; o_instret = instret1;
        end else begin
            o_estado = estado0; o_en = en0; o_halted = halted0; o_erro = erro0;
            o_causa = causa0; o_ciclos = ciclos0; o_instret = instret0;
        end
    end

    typedef struct {
        bit          s;
        logic [31:0] ins;
        int          k;      // MEM cycle on which ready rises; 0 = never
        int          cyc;
        logic [3:0]  fin;
        logic [1:0]  causa;
        int          ret;
        int          nmem;
        int          nwb;
    } vec_t;

    vec_t vt[16];

    function automatic logic [5:0] en_of(input logic [3:0] s);
        en_of = {s == ST_IF, s == ST_ID, s == ST_EX, s == ST_MEM, s == ST_WB, s == ST_SUMPC};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Expected per-cycle state trace of one instruction, straight from the class rules.
    task automatic build(input logic [31:0] ins, input int k, input int w1, input int w2);
        exp_q.delete();
        exp_q.push_back(ST_IF);
        exp_q.push_back(ST_ID);
        exp_q.push_back(ST_EX);
        repeat (w1) exp_q.push_back(ST_EXW);
        case (ins[6:0])
            7'b0000011: begin
                repeat (k) exp_q.push_back(ST_MEM);
                exp_q.push_back(ST_WB);
                repeat (w2) exp_q.push_back(ST_WBW);
            end
            7'b0100011: repeat (k) exp_q.push_back(ST_MEM);
            7'b1100011: ;
            default: begin
                exp_q.push_back(ST_WB);
                repeat (w2) exp_q.push_back(ST_WBW);
            end
        endcase
        exp_q.push_back(ST_SUMPC);
    endtask

    task automatic run_vec(input vec_t v, input bit with_reset);
        int n, memc, nmem, nwb;
        sel = v.s;
        if (with_reset) do_reset();
        instrucao = v.ins;
        n = 0; memc = 0; nmem = 0; nwb = 0;
        do begin
            if (o_en[2]) nmem++;
            if (o_en[1]) nwb++;
            if (o_estado == ST_MEM) begin
                memc++;
                mem_ready = (v.k != 0) && (memc == v.k);
            end else begin
                mem_ready = 1'b0;
            end
            @(negedge clk);
            n++;
        end while (n < 200 && !(o_estado == ST_IF || o_estado == ST_FIM || o_estado == ST_ERRO));
        mem_ready = 1'b0;
        chk($sformatf("vec_%08h_cycles", v.ins), 32'(n), 32'(v.cyc));
        chk($sformatf("vec_%08h_estado", v.ins), 32'(o_estado), 32'(v.fin));
        chk($sformatf("vec_%08h_causa", v.ins), 32'(o_causa), 32'(v.causa));
        chk($sformatf("vec_%08h_ciclos", v.ins), o_ciclos, 32'(v.cyc));
        chk($sformatf("vec_%08h_instret", v.ins), o_instret, 32'(v.ret));
        chk($sformatf("vec_%08h_en_mem_cnt", v.ins), 32'(nmem), 32'(v.nmem));
        chk($sformatf("vec_%08h_en_wb_cnt", v.ins), 32'(nwb), 32'(v.nwb));
        chk($sformatf("vec_%08h_flags", v.ins), 32'({o_halted, o_erro, o_en}),
            32'({v.fin == ST_FIM, v.fin == ST_ERRO, en_of(v.fin)}));
        if (v.fin != ST_IF) begin
            // Terminal states must hold and freeze ciclos whatever the inputs do.
            repeat (3) begin
                instrucao = $urandom();
                mem_ready = 1'b1;
                @(negedge clk);
            end
            mem_ready = 1'b0;
            chk($sformatf("vec_%08h_sticky", v.ins), 32'({o_estado, o_causa}), 32'({v.fin, v.causa}));
            chk($sformatf("vec_%08h_ciclos_frozen", v.ins), o_ciclos, 32'(v.cyc));
        end
    endtask

    task automatic rand_run(input bit s, input int ninst);
        int cyc, ret, memc, k, w, tmo;
        logic [31:0] ins;
        sel = s;
        w = s ? 0 : 2;
        tmo = s ? 3 : 15;
        do_reset();
        cyc = 0; ret = 0;
        for (int i = 0; i < ninst; i++) begin
            ins = $urandom();
            case ($urandom_range(0, 4))
                0: ins[6:0] = 7'b0000011;
                1: ins[6:0] = 7'b0100011;
                2: ins[6:0] = 7'b0110011;
                3: ins[6:0] = 7'b0010011;
                default: ins[6:0] = 7'b1100011;
            endcase
            k = $urandom_range(1, tmo);
            build(ins, k, w, w);
            memc = 0;
            foreach (exp_q[j]) begin
                chk("rnd_state", 32'({o_estado, o_en, o_halted, o_erro, o_causa}),
                    32'({exp_q[j], en_of(exp_q[j]), 4'b0000}));
                chk("rnd_ciclos", o_ciclos, 32'(cyc));
                chk("rnd_instret", o_instret, 32'(ret));
                instrucao = (exp_q[j] == ST_ID) ? ins : $urandom();
                if (exp_q[j] == ST_MEM) begin
                    memc++;
                    mem_ready = (memc == k);
                end else begin
                    mem_ready = 1'($urandom_range(0, 1));
                end
                @(negedge clk);
                cyc++;
                if (exp_q[j] == ST_SUMPC) ret++;
            end
        end
        mem_ready = 1'b0;
        chk("rnd_end_state", 32'(o_estado), 32'(ST_IF));
        chk("rnd_end_instret", o_instret, 32'(ninst));
    endtask

    initial begin
        int w;
        vt[0]  = '{0, 32'h40208033, 1,  9, ST_IF,   2'b00, 1, 0,  1};
        vt[1]  = '{0, 32'h00002083, 4, 13, ST_IF,   2'b00, 1, 4,  1};
        vt[2]  = '{1, 32'h00208063, 1,  4, ST_IF,   2'b00, 1, 0,  0};
        vt[3]  = '{0, 32'h00112023, 0, 20, ST_ERRO, 2'b10, 0, 15, 0};
        vt[4]  = '{0, 32'h0000007F, 1,  2, ST_ERRO, 2'b01, 0, 0,  0};
        vt[5]  = '{0, 32'h00000000, 1,  2, ST_FIM,  2'b00, 0, 0,  0};
        vt[6]  = '{0, 32'h00500093, 1,  9, ST_IF,   2'b00, 1, 0,  1};
        vt[7]  = '{0, 32'h00208063, 1,  6, ST_IF,   2'b00, 1, 0,  0};
        vt[8]  = '{0, 32'h00112023, 1,  7, ST_IF,   2'b00, 1, 1,  0};
        vt[9]  = '{1, 32'h00002083, 2,  7, ST_IF,   2'b00, 1, 2,  1};
        vt[10] = '{1, 32'h0020c0b3, 1,  5, ST_IF,   2'b00, 1, 0,  1};
        vt[11] = '{1, 32'h00112023, 0,  6, ST_ERRO, 2'b10, 0, 3,  0};
        vt[12] = '{0, 32'h0020d0b3, 1,  9, ST_IF,   2'b00, 1, 0,  1};
        vt[13] = '{1, 32'h00000073, 1,  2, ST_ERRO, 2'b01, 0, 0,  0};
        vt[14] = '{0, 32'h00002083, 15, 24, ST_IF,  2'b00, 1, 15, 1};
        vt[15] = '{1, 32'h00112023, 3,  7, ST_IF,   2'b00, 1, 3,  0};

        // Reset state of both configurations.
        do_reset();
        for (int s = 0; s < 2; s++) begin
            sel = bit'(s);
            #1;
            chk("reset_state", 32'({o_estado, o_en, o_halted, o_erro, o_causa}),
                32'({ST_IF, 6'b100000, 4'b0000}));
            chk("reset_ciclos", o_ciclos, 32'd0);
            chk("reset_instret", o_instret, 32'd0);
        end

        for (int i = 0; i < 16; i++) run_vec(vt[i], 1'b1);

        // Reset during the third MEM cycle of a stalled load, then a clean sub.
        sel = 1'b0;
        do_reset();
        instrucao = 32'h00002083;
        w = 0;
        while (o_estado != ST_MEM && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("midmem_reach", 32'(o_estado), 32'(ST_MEM));
        repeat (2) @(negedge clk);
        chk("midmem_third", 32'(o_estado), 32'(ST_MEM));
        rst = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'b0;
        chk("midmem_rst_state", 32'({o_estado, o_en, o_halted, o_erro, o_causa}),
            32'({ST_IF, 6'b100000, 4'b0000}));
        chk("midmem_rst_ciclos", o_ciclos, 32'd0);
        chk("midmem_rst_instret", o_instret, 32'd0);
        run_vec(vt[0], 1'b0);

        rand_run(1'b0, 30);
        rand_run(1'b1, 40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
